// File: rtl/data_mem_if.sv
// Load/store port between the core's M stage and the data-memory responder.
// The core drives the master side; the responder implements the slave side.
interface data_mem_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  stall, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output stall, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Multi-cycle byte-addressed data memory for the M stage: one access at a time,
// RV32I sizing/extension, result after LATENCY cycles while the core is stalled.
module data_mem_responder #(
    parameter int ADDRESS_WIDTH = 17,
    parameter int DATA_WIDTH    = 32,
    parameter int LATENCY       = 2
) (
    input logic       clk,
    input logic       rst,
    data_mem_if.slave bus
);

    localparam int MEM_BYTES = 1 << ADDRESS_WIDTH;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [3:0]               cnt_q, cnt_d;
    logic                     we_q, we_d;
    logic [2:0]               f3_q, f3_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
    logic                     err_q, err_d;

    logic [7:0] mem [MEM_BYTES];

    logic                     cur_we;
    logic [2:0]               cur_f3;
    logic [ADDRESS_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0]    cur_wdata;
    logic [ADDRESS_WIDTH-1:0] a1, a2, a3;
    logic [7:0]               b0, b1, b2, b3;
    logic                     bad;
    logic [DATA_WIDTH-1:0]    ext;
    logic                     go_resp;
    logic                     wr_en;
    logic                     unused_addr_hi;

    assign unused_addr_hi = ^bus.req_addr[31:ADDRESS_WIDTH];

    // In IDLE the live request is used so LATENCY=1 can finish on the accept edge
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_we    = bus.req_we;
            cur_f3    = bus.req_funct3;
            cur_addr  = bus.req_addr[ADDRESS_WIDTH-1:0];
            cur_wdata = bus.req_wdata;
        end else begin
            cur_we    = we_q;
            cur_f3    = f3_q;
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
        end
    end

    assign a1 = cur_addr + ADDRESS_WIDTH'(1);
    assign a2 = cur_addr + ADDRESS_WIDTH'(2);
    assign a3 = cur_addr + ADDRESS_WIDTH'(3);
    assign b0 = mem[cur_addr];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        bad = 1'b1;
        ext = '0;
        unique case (1'b1)
            cur_f3 == 3'b000: begin
                bad = 1'b0;
                ext = {{24{b0[7]}}, b0};
            end
            cur_f3 == 3'b001: begin
                bad = cur_addr[0];
                ext = {{16{b1[7]}}, b1, b0};
            end
            cur_f3 == 3'b010: begin
                bad = |cur_addr[1:0];
                ext = {b3, b2, b1, b0};
            end
            cur_f3 == 3'b100: begin
                bad = cur_we;
                ext = {24'h0, b0};
            end
            cur_f3 == 3'b101: begin
                bad = cur_we | cur_addr[0];
                ext = {16'h0, b1, b0};
            end
            default: begin
                bad = 1'b1;
                ext = '0;
            end
        endcase
    end

    assign go_resp = ((state_q == S_IDLE) && bus.req_valid && (LATENCY == 1))
                   || ((state_q == S_BUSY) && (cnt_q == 4'd1));
    assign wr_en = go_resp & cur_we & ~bad & ~rst;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (1'b1)
            state_q == S_IDLE: begin
                if (bus.req_valid) begin
                    we_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    addr_d  = bus.req_addr[ADDRESS_WIDTH-1:0];
                    wdata_d = bus.req_wdata;
                    cnt_d   = 4'(LATENCY - 1);
                    if (LATENCY == 1) state_d = S_RESP;
                    else              state_d = S_BUSY;
                end
            end
            state_q == S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_RESP;
            end
            state_q == S_RESP: state_d = S_IDLE;
            default:           state_d = S_IDLE;
        endcase
        if (go_resp) begin
            rdata_d = (bad | cur_we) ? '0 : ext;
            err_d   = bad;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            f3_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately not reset; only lanes covered by the size are written
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[cur_addr] <= cur_wdata[7:0];
            if (cur_f3[1:0] != 2'b00) mem[a1] <= cur_wdata[15:8];
            if (cur_f3[1]) begin
                mem[a2] <= cur_wdata[23:16];
                mem[a3] <= cur_wdata[31:24];
            end
        end
    end

    assign bus.resp_valid = (state_q == S_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;
    assign bus.stall      = bus.req_valid & ~bus.resp_valid;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench: two responders (LATENCY 2 and 1) driven from one stimulus
// sequence, expected responses queued at issue and compared at resp_valid.
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_if a_if ();
    data_mem_if b_if ();

    data_mem_responder #(.LATENCY(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if)
    );

    data_mem_responder #(.LATENCY(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if)
    );

    int n_vec = 0;
    int n_bad = 0;
    int unsigned cyc = 0;
    logic [32:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h want %08h", tag, got, exp);
        end
    endtask

    function automatic logic rv(input bit s);
        return s ? b_if.resp_valid : a_if.resp_valid;
    endfunction

    function automatic logic st(input bit s);
        return s ? b_if.stall : a_if.stall;
    endfunction

    function automatic logic vl(input bit s);
        return s ? b_if.req_valid : a_if.req_valid;
    endfunction

    task automatic drive(input bit we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        a_if.req_we = we;     b_if.req_we = we;
        a_if.req_funct3 = f3; b_if.req_funct3 = f3;
        a_if.req_addr = addr; b_if.req_addr = addr;
        a_if.req_wdata = wd;  b_if.req_wdata = wd;
    endtask

    task automatic set_valid(input bit s, input bit v);
        if (s) b_if.req_valid = v;
        else   a_if.req_valid = v;
    endtask

    task automatic xfer(input bit s, input string tag, input bit we,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd,
                        input bit exp_err, input bit flush,
                        output int unsigned c0, output int unsigned c1);
        int lat;
        int n;
        logic [32:0] e;
        exp_q.push_back({exp_err, exp_rd});
        @(negedge clk);
        check({tag, "/idle"}, 32'(rv(s)), 32'd0);
        drive(we, f3, addr, wd);
        set_valid(s, 1'b1);
        c0 = cyc;
        #1;
        lat = 0;
        n = 0;
        while (!rv(s) && n < 20) begin
            check({tag, "/stall"}, 32'(st(s)), 32'(vl(s)));
            lat++;
            @(negedge clk);
            drive(1'($urandom), 3'($urandom), $urandom, $urandom);
            if (flush) set_valid(s, 1'b0);
            #1;
            n++;
        end
        c1 = cyc;
        check({tag, "/lat"}, 32'(lat), s ? 32'd1 : 32'd2);
        check({tag, "/st0"}, 32'(st(s)), 32'd0);
        e = exp_q.pop_front();
        check({tag, "/rd"}, s ? b_if.resp_rdata : a_if.resp_rdata, e[31:0]);
        check({tag, "/err"}, 32'(s ? b_if.resp_err : a_if.resp_err), 32'(e[32]));
    endtask

    task automatic idle();
        @(negedge clk);
        a_if.req_valid = 1'b0;
        b_if.req_valid = 1'b0;
        #1;
        check("idle/stall", 32'(a_if.stall | b_if.stall), 32'd0);
    endtask

    int unsigned c0, c1, d0, d1;

    initial begin
        rst = 1'b1;
        a_if.req_valid = 1'b0;
        b_if.req_valid = 1'b0;
        drive(1'b0, 3'b000, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        check("rst/rv", 32'(a_if.resp_valid), 32'd0);
        check("rst/rd", a_if.resp_rdata, 32'd0);
        check("rst/err", 32'(a_if.resp_err), 32'd0);
        check("rst/stall", 32'(a_if.stall), 32'd0);
        rst = 1'b0;

        xfer(0, "sw100", 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, c0, c1);
        xfer(0, "lw100", 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0, c0, c1);
        idle();
        xfer(0, "sb101", 1, 3'b000, 32'h101, 32'hAAAA5580, 32'h0, 0, 0, c0, c1);
        xfer(0, "lb101", 0, 3'b000, 32'h101, 32'h0, 32'hFFFFFF80, 0, 0, c0, c1);
        xfer(0, "lbu101", 0, 3'b100, 32'h101, 32'h0, 32'h00000080, 0, 0, c0, c1);
        xfer(0, "lw100b", 0, 3'b010, 32'h100, 32'h0, 32'hDEAD80EF, 0, 0, c0, c1);
        idle();
        xfer(0, "lh102", 0, 3'b001, 32'h102, 32'h0, 32'hFFFFDEAD, 0, 0, c0, c1);
        xfer(0, "lhu102", 0, 3'b101, 32'h102, 32'h0, 32'h0000DEAD, 0, 0, c0, c1);
        xfer(0, "lw102", 0, 3'b010, 32'h102, 32'h0, 32'h0, 1, 0, c0, c1);
        xfer(0, "sh103", 1, 3'b001, 32'h103, 32'h5555, 32'h0, 1, 0, c0, c1);
        xfer(0, "ld011", 0, 3'b011, 32'h100, 32'h0, 32'h0, 1, 0, c0, c1);
        xfer(0, "st100", 1, 3'b100, 32'h100, 32'h11111111, 32'h0, 1, 0, c0, c1);
        xfer(0, "lw100c", 0, 3'b010, 32'h100, 32'h0, 32'hDEAD80EF, 0, 0, c0, c1);
        xfer(0, "lb103", 0, 3'b000, 32'h103, 32'h0, 32'hFFFFFFDE, 0, 0, c0, c1);
        xfer(0, "sh102", 1, 3'b001, 32'h102, 32'hFFFF1234, 32'h0, 0, 0, c0, c1);
        xfer(0, "lw100d", 0, 3'b010, 32'h100, 32'h0, 32'h123480EF, 0, 0, c0, c1);
        idle();

        xfer(0, "b2b_sw", 1, 3'b010, 32'h0, 32'hCAFEF00D, 32'h0, 0, 0, c0, c1);
        xfer(0, "b2b_lw", 0, 3'b010, 32'h0, 32'h0, 32'hCAFEF00D, 0, 0, d0, d1);
        check("b2b/accept", d0 - c1, 32'd1);
        check("b2b/total", d1 - c0, 32'd5);
        idle();

        xfer(0, "flush_sw", 1, 3'b010, 32'h300, 32'h000055AA, 32'h0, 0, 1, c0, c1);
        xfer(0, "flush_lw", 0, 3'b010, 32'h300, 32'h0, 32'h000055AA, 0, 0, c0, c1);
        xfer(0, "sw200", 1, 3'b010, 32'h200, 32'h0, 32'h0, 0, 0, c0, c1);
        xfer(0, "lw100e", 0, 3'b010, 32'h100, 32'h0, 32'h123480EF, 0, 0, c0, c1);
        idle();

        @(negedge clk);
        drive(1'b1, 3'b010, 32'h200, 32'h12345678);
        a_if.req_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        a_if.req_valid = 1'b0;
        #1;
        check("rst2/rv", 32'(a_if.resp_valid), 32'd0);
        check("rst2/rd", a_if.resp_rdata, 32'd0);
        check("rst2/err", 32'(a_if.resp_err), 32'd0);
        check("rst2/stall", 32'(a_if.stall), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst2/nopulse", 32'(a_if.resp_valid), 32'd0);
        end
        xfer(0, "lw200", 0, 3'b010, 32'h200, 32'h0, 32'h0, 0, 0, c0, c1);
        idle();

        xfer(1, "l1_sw", 1, 3'b010, 32'h1FFFC, 32'h0BADF00D, 32'h0, 0, 0, c0, c1);
        xfer(1, "l1_lw", 0, 3'b010, 32'h1FFFC, 32'h0, 32'h0BADF00D, 0, 0, c0, c1);
        xfer(1, "l1_wrap", 0, 3'b010, 32'h3FFFC, 32'h0, 32'h0BADF00D, 0, 0, c0, c1);
        xfer(1, "l1_lhu", 0, 3'b101, 32'hFFFDFFFE, 32'h0, 32'h00000BAD, 0, 0, c0, c1);
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
